mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port (CPU / program loader) arbiter in front of a shared single-port synchronous memory.
// Fixed three-cycle access; define ARB_ROUND_ROBIN_EN for round-robin instead of loader priority.
module mem_port_arbiter #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic              cpu_ack,
   output logic [31:0]       cpu_rdata,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [31:0]       ld_wdata,
   output logic              ld_ack,
   output logic [31:0]       ld_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      ID_CPU = 1'b0,
      ID_LD  = 1'b1
   } id_t;

   state_t            state;
   id_t               lat_id;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [31:0]       lat_wdata;

   id_t               winner;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [31:0]       sel_wdata;

`ifdef ARB_ROUND_ROBIN_EN
   id_t last_grant;

   // On a tie the requester that did not win last time goes first.
   always_comb begin
      winner = ID_LD;
      if (cpu_req && ld_req)
         winner = (last_grant == ID_LD) ? ID_CPU : ID_LD;
      else if (cpu_req)
         winner = ID_CPU;
   end

   always_ff @(posedge clk) begin
      if (rst)
         last_grant <= ID_LD;
      else if (state == IDLE && (cpu_req || ld_req))
         last_grant <= winner;
   end
`else
   always_comb begin
      winner = ld_req ? ID_LD : ID_CPU;
   end
`endif

   // NOTE: every output of an always_comb gets a default first so no latch is inferred.
   always_comb begin
      sel_we    = cpu_we;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
      if (winner == ID_LD) begin
         sel_we    = ld_we;
         sel_addr  = ld_addr;
         sel_wdata = ld_wdata;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         lat_id    <= ID_CPU;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         cpu_ack   <= 1'b0;
         ld_ack    <= 1'b0;
         cpu_rdata <= '0;
         ld_rdata  <= '0;
      end else begin
         cpu_ack <= 1'b0;
         ld_ack  <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_req || ld_req) begin
                  state     <= ACCESS;
                  lat_id    <= winner;
                  lat_we    <= sel_we;
                  lat_addr  <= sel_addr;
                  lat_wdata <= sel_wdata;
               end
            end
            ACCESS: state <= RESP;
            RESP: begin
               // mem_rdata now reflects the address presented during ACCESS.
               state <= IDLE;
               if (lat_id == ID_CPU) begin
                  cpu_ack   <= 1'b1;
                  cpu_rdata <= mem_rdata;
               end else begin
                  ld_ack   <= 1'b1;
                  ld_rdata <= mem_rdata;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Memory side is driven straight from the latched request, so late input changes cannot leak in.
   assign mem_we    = (state == ACCESS) && lat_we;
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;
   assign busy      = (state != IDLE);

endmodule
